// File: rtl/lsram_port_arbiter.sv
//----------------------------------------------------------------------------
// lsram_port_arbiter
//
// Shares one LSRAM port between two requesters (m0, m1) with round-robin
// arbitration. At most one request is accepted per cycle. The RAM address,
// write data and write enable are driven combinationally from the winner.
// Reads are tracked through a latency shift register so that each read
// response strobes on the correct requester exactly L cycles after the
// accept cycle, carrying ram_dout as seen in that cycle.
//
// Build option:
//   LSRAM_PIPE_EN  defined   -> L = 2 (RAM output register + pipeline register)
//                  undefined -> L = 1 (RAM output register only)
//
// Ports:
//   aclk, areset                 clock, synchronous active-high reset
//   mN_valid/mN_ready            request handshake (accept = valid & ready)
//   mN_we/mN_addr/mN_wdata       request payload (we: 0 = read, 1 = write)
//   mN_rvalid/mN_rdata           one-cycle read response strobe and data
//   ram_we/ram_addr/ram_din      LSRAM port controls
//   ram_dout                     LSRAM port read data
//----------------------------------------------------------------------------
module lsram_port_arbiter #(
    parameter int DATA_WIDTH = 18,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  aclk,
    input  logic                  areset,

    input  logic                  m0_valid,
    output logic                  m0_ready,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_rvalid,
    output logic [DATA_WIDTH-1:0] m0_rdata,

    input  logic                  m1_valid,
    output logic                  m1_ready,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_rvalid,
    output logic [DATA_WIDTH-1:0] m1_rdata,

    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

`ifdef LSRAM_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic                  last_reg;    // 1 = m1 was granted most recently
    logic                  grant0;
    logic                  grant1;
    logic                  accept;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_din;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!areset) begin
            if (m0_valid && m1_valid) begin
                // Contention: whoever did not win last time wins now.
                grant0 = last_reg;
                grant1 = ~last_reg;
            end else begin
                grant0 = m0_valid;
                grant1 = m1_valid;
            end
        end
    end

    assign m0_ready = grant0;
    assign m1_ready = grant1;
    assign accept   = grant0 | grant1;

    assign sel_we   = grant1 ? m1_we    : m0_we;
    assign sel_addr = grant1 ? m1_addr  : m0_addr;
    assign sel_din  = grant1 ? m1_wdata : m0_wdata;

    // ------------------------------------------------------------------
    // RAM port drive: live from the winner on an accept, otherwise the
    // address/data hold their last driven values and the write is off.
    // ------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [DATA_WIDTH-1:0] din_reg;

    assign ram_we   = accept & sel_we;
    assign ram_addr = accept ? sel_addr : addr_reg;
    assign ram_din  = accept ? sel_din  : din_reg;

    always_ff @(posedge aclk) begin
        if (areset) begin
            last_reg <= 1'b1;   // m0 wins the first contention
            addr_reg <= '0;
            din_reg  <= '0;
        end else if (accept) begin
            last_reg <= grant1;
            addr_reg <= sel_addr;
            din_reg  <= sel_din;
        end
    end

    // ------------------------------------------------------------------
    // Read latency tracker: stage 0 captures {read accepted, requester id};
    // the last stage lines up with the cycle in which ram_dout is valid.
    // ------------------------------------------------------------------
    logic [LAT-1:0] lat_valid_reg;
    logic [LAT-1:0] lat_id_reg;
    logic [LAT-1:0] lat_valid_next;
    logic [LAT-1:0] lat_id_next;

    assign lat_valid_next[0] = accept & ~sel_we;
    assign lat_id_next[0]    = grant1;

    genvar gi;
    generate
        for (gi = 1; gi < LAT; gi++) begin : g_lat
            assign lat_valid_next[gi] = lat_valid_reg[gi-1];
            assign lat_id_next[gi]    = lat_id_reg[gi-1];
        end
    endgenerate

    always_ff @(posedge aclk) begin
        if (areset) begin
            lat_valid_reg <= '0;    // in-flight reads are dropped
            lat_id_reg    <= '0;
        end else begin
            lat_valid_reg <= lat_valid_next;
            lat_id_reg    <= lat_id_next;
        end
    end

    // ------------------------------------------------------------------
    // Response outputs: rdata passes ram_dout through on the strobe cycle
    // and otherwise shows the last delivered value.
    // ------------------------------------------------------------------
    logic                  resp_valid;
    logic                  resp_id;
    logic [DATA_WIDTH-1:0] rdata0_reg;
    logic [DATA_WIDTH-1:0] rdata1_reg;

    assign resp_valid = lat_valid_reg[LAT-1] & ~areset;
    assign resp_id    = lat_id_reg[LAT-1];

    assign m0_rvalid = resp_valid & ~resp_id;
    assign m1_rvalid = resp_valid &  resp_id;
    assign m0_rdata  = m0_rvalid ? ram_dout : rdata0_reg;
    assign m1_rdata  = m1_rvalid ? ram_dout : rdata1_reg;

    always_ff @(posedge aclk) begin
        if (areset) begin
            rdata0_reg <= '0;
            rdata1_reg <= '0;
        end else begin
            if (m0_rvalid) begin
                rdata0_reg <= ram_dout;
            end
            if (m1_rvalid) begin
                rdata1_reg <= ram_dout;
            end
        end
    end

endmodule

// File: tb/tb_lsram_port_arbiter.sv
//----------------------------------------------------------------------------
// tb_lsram_port_arbiter
//
// Drives directed scenarios and then randomized traffic into the arbiter,
// with a simple LSRAM model on the RAM side. A behavioural model (grant
// rule, shadow memory, queue of expected responses with due cycles)
// predicts every output, and a compare process checks all outputs on every
// negative clock edge. Directed scenarios add literal expectations.
//----------------------------------------------------------------------------
module tb_lsram_port_arbiter;

    localparam int DW = 18;
    localparam int AW = 10;
`ifdef LSRAM_PIPE_EN
    localparam int L = 2;
`else
    localparam int L = 1;
`endif

    logic          aclk;
    logic          areset;
    logic          m0_valid, m1_valid;
    logic          m0_ready, m1_ready;
    logic          m0_we, m1_we;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic          m0_rvalid, m1_rvalid;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    lsram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .aclk      (aclk),
        .areset    (areset),
        .m0_valid  (m0_valid),
        .m0_ready  (m0_ready),
        .m0_we     (m0_we),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_rvalid (m0_rvalid),
        .m0_rdata  (m0_rdata),
        .m1_valid  (m1_valid),
        .m1_ready  (m1_ready),
        .m1_we     (m1_we),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_rvalid (m1_rvalid),
        .m1_rdata  (m1_rdata),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    // ------------------------------------------------------------------
    // LSRAM model: registered read (read-first), optional pipeline stage
    // ------------------------------------------------------------------
    logic [DW-1:0] ram_mem [1 << AW];
    logic [DW-1:0] ram_q1, ram_q2;

    initial begin
        for (int i = 0; i < (1 << AW); i++) ram_mem[i] = '0;
        ram_q1 = '0;
        ram_q2 = '0;
    end

    always @(posedge aclk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_din;
        ram_q1 <= ram_mem[ram_addr];
        ram_q2 <= ram_q1;
    end
    assign ram_dout = (L == 2) ? ram_q2 : ram_q1;

    // ------------------------------------------------------------------
    // Checking infrastructure
    // ------------------------------------------------------------------
    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    typedef struct {
        int            due;
        bit            id;
        logic [DW-1:0] data;
    } resp_t;

    typedef struct {
        bit            g0, g1, acc, we;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
        bit            rv0, rv1;
        logic [DW-1:0] rd0, rd1;
    } exp_t;

    resp_t         resp_q[$];
    logic [DW-1:0] shadow [1 << AW];
    bit            last_m    = 1'b1;   // 1 = m1 granted most recently
    logic [AW-1:0] held_addr = '0;
    logic [DW-1:0] held_din  = '0;
    logic [DW-1:0] hold_rd0  = '0;
    logic [DW-1:0] hold_rd1  = '0;
    int            cyc       = 0;
    bit            check_en  = 1'b0;

    initial for (int i = 0; i < (1 << AW); i++) shadow[i] = '0;

    function automatic exp_t model_eval();
        exp_t e;
        bit   due_now;
        e.g0   = !areset && m0_valid && (!m1_valid || last_m == 1'b1);
        e.g1   = !areset && m1_valid && (!m0_valid || last_m == 1'b0);
        e.acc  = e.g0 || e.g1;
        e.we   = e.acc && (e.g1 ? m1_we : m0_we);
        e.addr = e.acc ? (e.g1 ? m1_addr : m0_addr) : held_addr;
        e.din  = e.acc ? (e.g1 ? m1_wdata : m0_wdata) : held_din;
        due_now = !areset && (resp_q.size() > 0) && (resp_q[0].due == cyc);
        e.rv0  = due_now && (resp_q[0].id == 1'b0);
        e.rv1  = due_now && (resp_q[0].id == 1'b1);
        e.rd0  = e.rv0 ? resp_q[0].data : hold_rd0;
        e.rd1  = e.rv1 ? resp_q[0].data : hold_rd1;
        return e;
    endfunction

    always @(posedge aclk) begin : model_update
        exp_t e;
        e = model_eval();
        if (areset) begin
            resp_q.delete();
            last_m    = 1'b1;
            held_addr = '0;
            held_din  = '0;
            hold_rd0  = '0;
            hold_rd1  = '0;
            check_en  = 1'b1;
        end else begin
            if (e.rv0) hold_rd0 = e.rd0;
            if (e.rv1) hold_rd1 = e.rd1;
            if (e.rv0 || e.rv1) void'(resp_q.pop_front());
            if (e.acc) begin
                last_m    = e.g1;
                held_addr = e.addr;
                held_din  = e.din;
                if (e.we) shadow[e.addr] = e.din;
                else resp_q.push_back('{due: cyc + L, id: e.g1, data: shadow[e.addr]});
            end
        end
        cyc++;
    end

    always @(negedge aclk) begin : compare
        exp_t e;
        if (check_en) begin
            e = model_eval();
            chk("m0_ready",  32'(m0_ready),  32'(e.g0));
            chk("m1_ready",  32'(m1_ready),  32'(e.g1));
            chk("ram_we",    32'(ram_we),    32'(e.we));
            chk("ram_addr",  32'(ram_addr),  32'(e.addr));
            chk("ram_din",   32'(ram_din),   32'(e.din));
            chk("m0_rvalid", 32'(m0_rvalid), 32'(e.rv0));
            chk("m1_rvalid", 32'(m1_rvalid), 32'(e.rv1));
            chk("m0_rdata",  32'(m0_rdata),  32'(e.rd0));
            chk("m1_rdata",  32'(m1_rdata),  32'(e.rd1));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic idle();
        m0_valid = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_valid = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
    endtask

    task automatic req0(input logic we, input int addr, input int data);
        m0_valid = 1'b1; m0_we = we; m0_addr = AW'(addr); m0_wdata = DW'(data);
    endtask

    task automatic req1(input logic we, input int addr, input int data);
        m1_valid = 1'b1; m1_we = we; m1_addr = AW'(addr); m1_wdata = DW'(data);
    endtask

    // Reset with both requesters pushing; every output must read as zero
    // (address/data/rdata from the second reset cycle, once cleared).
    task automatic do_reset(input int n);
        areset = 1'b1;
        req0(1'b1, 5, 'h1234);
        req1(1'b0, 6, 'h0abc);
        for (int i = 0; i < n; i++) begin
            @(negedge aclk);
            chk("rst_m0_ready",  32'(m0_ready),  32'd0);
            chk("rst_m1_ready",  32'(m1_ready),  32'd0);
            chk("rst_ram_we",    32'(ram_we),    32'd0);
            chk("rst_m0_rvalid", 32'(m0_rvalid), 32'd0);
            chk("rst_m1_rvalid", 32'(m1_rvalid), 32'd0);
            if (i > 0) begin
                chk("rst_ram_addr", 32'(ram_addr), 32'd0);
                chk("rst_ram_din",  32'(ram_din),  32'd0);
                chk("rst_m0_rdata", 32'(m0_rdata), 32'd0);
                chk("rst_m1_rdata", 32'(m1_rdata), 32'd0);
            end
            tick();
        end
        areset = 1'b0;
        idle();
    endtask

    task automatic idle_cycles(input int n);
        idle();
        repeat (n) tick();
    endtask

    // ------------------------------------------------------------------
    // Directed scenarios followed by random traffic
    // ------------------------------------------------------------------
    initial begin
        areset = 1'b1;
        idle();
        tick();
        do_reset(2);

        // Write then read back on m0; response exactly L cycles later.
        req0(1'b1, 3, 'h155);
        @(negedge aclk);
        chk("wr_m0_ready", 32'(m0_ready), 32'd1);
        chk("wr_ram_we",   32'(ram_we),   32'd1);
        chk("wr_ram_addr", 32'(ram_addr), 32'd3);
        chk("wr_ram_din",  32'(ram_din),  32'h155);
        tick();
        idle();
        req0(1'b0, 3, 0);
        @(negedge aclk);
        chk("rd_m0_ready", 32'(m0_ready), 32'd1);
        chk("rd_ram_we",   32'(ram_we),   32'd0);
        tick();
        idle();
        for (int k = 1; k <= L; k++) begin
            @(negedge aclk);
            chk("rd_m0_rvalid", 32'(m0_rvalid), 32'(k == L));
            chk("rd_m1_rvalid", 32'(m1_rvalid), 32'd0);
            if (k == L) chk("rd_m0_rdata", 32'(m0_rdata), 32'h155);
            tick();
        end
        idle_cycles(2);

        // Contention right after reset alternates m0, m1, m0, m1.
        do_reset(2);
        req0(1'b0, 'h11, 0);
        req1(1'b0, 'h22, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge aclk);
            chk("rr_m0_ready", 32'(m0_ready), 32'(k % 2 == 0));
            chk("rr_m1_ready", 32'(m1_ready), 32'(k % 2 == 1));
            chk("rr_ram_addr", 32'(ram_addr), (k % 2 == 0) ? 32'h11 : 32'h22);
            tick();
        end
        idle_cycles(L + 1);

        // Back-to-back reads from m1 then m0 give back-to-back responses.
        req1(1'b1, 7, 'h0aa);
        tick();
        idle();
        req0(1'b1, 8, 'h3ff);
        tick();
        for (int k = 0; k <= L + 2; k++) begin
            idle();
            if (k == 0) req1(1'b0, 7, 0);
            if (k == 1) req0(1'b0, 8, 0);
            @(negedge aclk);
            chk("b2b_m1_rvalid", 32'(m1_rvalid), 32'(k == L));
            chk("b2b_m0_rvalid", 32'(m0_rvalid), 32'(k == L + 1));
            if (k == L)     chk("b2b_m1_rdata", 32'(m1_rdata), 32'h0aa);
            if (k == L + 1) chk("b2b_m0_rdata", 32'(m0_rdata), 32'h3ff);
            tick();
        end
        idle_cycles(2);

        // Sole m1 requester is always granted; then m0 wins a collision.
        for (int k = 0; k < 3; k++) begin
            idle();
            req1(1'b1, 'h30 + k, 'h100 + k);
            @(negedge aclk);
            chk("solo_m1_ready", 32'(m1_ready), 32'd1);
            chk("solo_m0_ready", 32'(m0_ready), 32'd0);
            tick();
        end
        req0(1'b1, 'h40, 'h7);
        req1(1'b1, 'h41, 'h8);
        @(negedge aclk);
        chk("coll_m0_ready", 32'(m0_ready), 32'd1);
        chk("coll_m1_ready", 32'(m1_ready), 32'd0);
        tick();
        idle_cycles(L + 1);

        // Reset one cycle after a read accept drops the response.
        req0(1'b0, 3, 0);
        @(negedge aclk);
        chk("drop_m0_ready", 32'(m0_ready), 32'd1);
        tick();
        do_reset(2);
        for (int k = 0; k < L + 2; k++) begin
            @(negedge aclk);
            chk("drop_m0_rvalid", 32'(m0_rvalid), 32'd0);
            chk("drop_m1_rvalid", 32'(m1_rvalid), 32'd0);
            tick();
        end

        // Random traffic with occasional resets and boundary addresses.
        for (int n = 0; n < 600; n++) begin
            areset   = ($urandom_range(0, 63) == 0);
            m0_valid = $urandom_range(0, 99) < 60;
            m1_valid = $urandom_range(0, 99) < 60;
            m0_we    = $urandom_range(0, 1) == 1;
            m1_we    = $urandom_range(0, 1) == 1;
            m0_addr  = ($urandom_range(0, 7) == 0) ? AW'((1 << AW) - 1) : AW'($urandom_range(0, 15));
            m1_addr  = ($urandom_range(0, 7) == 0) ? AW'((1 << AW) - 1) : AW'($urandom_range(0, 15));
            m0_wdata = DW'($urandom);
            m1_wdata = DW'($urandom);
            tick();
        end
        areset = 1'b0;
        idle_cycles(L + 3);

        @(negedge aclk);
        #1;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/lsram_port_arbiter.md
LSRAM_PORT_ARBITER -- requirements
Module: lsram_port_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 18, meaning the LSRAM port data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, meaning the LSRAM port address width (1k x 18 mode).
REQ-003 SHALL have port aclk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port areset, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have ports m0_valid, input, 1 bit, and m1_valid, input, 1 bit: requester n presents a request.
REQ-006 SHALL have ports m0_ready, output, 1 bit, and m1_ready, output, 1 bit: request accepted this cycle.
REQ-007 SHALL have ports m0_we, input, 1 bit, and m1_we, input, 1 bit: 0 = read, 1 = write.
REQ-008 SHALL have ports m0_addr, input, ADDR_WIDTH bits, and m1_addr, input, ADDR_WIDTH bits: request address.
REQ-009 SHALL have ports m0_wdata, input, DATA_WIDTH bits, and m1_wdata, input, DATA_WIDTH bits: write data.
REQ-010 SHALL have ports m0_rvalid, output, 1 bit, and m1_rvalid, output, 1 bit: one-cycle read-response strobe.
REQ-011 SHALL have ports m0_rdata, output, DATA_WIDTH bits, and m1_rdata, output, DATA_WIDTH bits: read-response data.
REQ-012 SHALL have port ram_we, output, 1 bit: LSRAM port write enable.
REQ-013 SHALL have port ram_addr, output, ADDR_WIDTH bits: LSRAM port address.
REQ-014 SHALL have port ram_din, output, DATA_WIDTH bits: LSRAM port write data.
REQ-015 SHALL have port ram_dout, input, DATA_WIDTH bits: LSRAM port read data.

Function
REQ-016 SHALL accept at most one request per cycle; accept_n = mn_valid & mn_ready.
REQ-017 SHALL derive mn_ready combinationally: a sole valid requester is granted; on contention, the requester not granted last wins (round-robin).
REQ-018 SHALL update the last-grant pointer only on an accept; idle cycles leave it unchanged.
REQ-019 SHALL drive ram_we/ram_addr/ram_din combinationally from the granted requester in the accept cycle; with no accept, ram_we = 0 and ram_addr/ram_din hold their last driven values.
REQ-020 SHALL track each accepted read in a latency shift register of {valid, requester id}, depth L (REQ-033/034).
REQ-021 SHALL assert mn_rvalid for exactly one cycle, L cycles after the read's accept cycle, with mn_rdata = ram_dout in that cycle.
REQ-022 SHALL hold mn_rdata at its last value when mn_rvalid = 0; writes produce no response.
REQ-023 SHALL return responses in acceptance order; back-to-back reads yield back-to-back rvalid with no bubble and no response backpressure.
REQ-024 SHALL not check write/read collisions with the other LSRAM port (no collision detection, as for the LSRAM itself).
REQ-025 SHALL let a requester change valid/addr while not accepted; no stability rule applies before acceptance.

Reset
REQ-026 SHALL, while areset = 1: m0_ready = m1_ready = 0, ram_we = 0, m0_rvalid = m1_rvalid = 0.
REQ-027 SHALL on reset clear the latency shift register, dropping in-flight reads (no rvalid after reset release).
REQ-028 SHALL on reset set the last-grant pointer to m1, so m0 wins the first contention.
REQ-029 SHALL on reset set ram_addr, ram_din, m0_rdata and m1_rdata to 0.
REQ-030 SHALL accept requests from the first cycle with areset = 0.

Configuration
REQ-031 SHALL use macro LSRAM_PIPE_EN to select read latency to match the LSRAM optional read pipeline register.
REQ-032 SHALL share arbitration logic between both builds; only L differs.
REQ-033 SHALL, with LSRAM_PIPE_EN defined, use L = 2 (RAM read register plus pipeline register).
REQ-034 SHALL, without LSRAM_PIPE_EN, use L = 1.

Verification
REQ-035 SHALL cover: reset, then m0 writes 0x155 to addr 3, then m0 reads addr 3 -> m0_rvalid=1, m0_rdata=0x155 exactly L cycles after read accept; m1_rvalid stays 0.
REQ-036 SHALL cover: m0 and m1 both valid for 4 cycles after reset -> grants m0,m1,m0,m1; ram_addr follows the winner each cycle.
REQ-037 SHALL cover: m1 reads addr 7 (0x0AA) then m0 reads addr 8 (0x3FF) back-to-back -> m1_rvalid then m0_rvalid on consecutive cycles with the correct data.
REQ-038 SHALL cover: areset asserted 1 cycle after a read accept -> no rvalid ever appears for that read; all outputs 0 during reset.
REQ-039 SHALL cover: only m1 valid for 3 cycles -> m1_ready=1 every cycle; then a collision -> m0 granted.
REQ-040 SHALL run every scenario with and without LSRAM_PIPE_EN, checking L = 2 and L = 1 respectively.
